// File: rtl/geofence_pkg.sv
// Shared constants, state encoding and address helper for the geofence host/judge pair.
package geofence_pkg;
    localparam int COORD_W        = 10;
    localparam int POINTS_PER_OBJ = 7;
    localparam int MAX_OBJ        = 64;
    localparam int OBJ_W          = 6;
    localparam int ADDR_W         = 9;
    localparam int TIMEOUT        = 1023;
    localparam int TO_W           = 10;

    localparam logic [2:0] LAST_PT = 3'(POINTS_PER_OBJ - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRIME, ST_SEND, ST_WAIT, ST_RECORD, ST_DONE, ST_ERR
    } state_t;

    // obj*7 as (obj<<3)-obj; 63*7 still fits in ADDR_W
    function automatic logic [ADDR_W-1:0] obj_base(input logic [OBJ_W-1:0] obj);
        return ADDR_W'({obj, 3'b000}) - ADDR_W'(obj);
    endfunction
endpackage

// File: rtl/geofence_host_if.sv
// Host-side bus: run control, point ROM, judge handshake and result RAM.
interface geofence_host_if;
    import geofence_pkg::*;

    logic               start;
    logic [OBJ_W:0]     num_obj;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COORD_W-1:0] mem_x;
    logic [COORD_W-1:0] mem_y;
    logic [COORD_W-1:0] X;
    logic [COORD_W-1:0] Y;
    logic               pt_vld;
    logic               valid;
    logic               is_inside;
    logic               res_we;
    logic [OBJ_W-1:0]   res_addr;
    logic               res_data;
    logic [OBJ_W:0]     inside_cnt;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  start, num_obj, mem_x, mem_y, valid, is_inside,
        output mem_addr, X, Y, pt_vld, res_we, res_addr, res_data,
               inside_cnt, busy, done, err
    );
    modport slave (
        output start, num_obj, mem_x, mem_y, valid, is_inside,
        input  mem_addr, X, Y, pt_vld, res_we, res_addr, res_data,
               inside_cnt, busy, done, err
    );
endinterface

// File: rtl/geofence_host_tmr.sv
// Judge response watchdog: counts WAIT cycles and flags expiry at the limit.
module geofence_host_tmr #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] r_cnt;

    assign o_expire = (r_cnt == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_cnt <= '0;
        else if (i_clr)             r_cnt <= '0;
        else if (i_en && !o_expire) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/geofence_host.sv
// Geofence stimulus/collection master: streams 7 points per object from the
// point ROM, waits for the judge verdict and logs one result bit per object.
module geofence_host
    import geofence_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    geofence_host_if.master bus
);
    state_t               r_state, w_state_nxt;
    logic [OBJ_W-1:0]     r_obj;
    logic [OBJ_W:0]       r_num;
    logic [OBJ_W:0]       r_inside_cnt;
    logic [2:0]           r_pt;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [COORD_W-1:0]   r_x, r_y;
    logic                 r_pt_vld;
    logic                 r_inside;
    logic                 w_busy, w_viol, w_last, w_to_exp;

    assign w_busy = r_state inside {ST_PRIME, ST_SEND, ST_WAIT, ST_RECORD};
    assign w_viol = w_busy && (r_state != ST_WAIT) && bus.valid;
    assign w_last = ({1'b0, r_obj} == (r_num - 1'b1));

    geofence_host_tmr #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_tmr (
        .clk      (clk),
        .reset    (reset),
        .i_clr    ((r_state == ST_SEND) && (r_pt == LAST_PT)),
        .i_en     (r_state == ST_WAIT),
        .o_expire (w_to_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR:
                if (bus.start) w_state_nxt = (bus.num_obj == '0) ? ST_DONE : ST_PRIME;
            ST_PRIME:  w_state_nxt = ST_SEND;
            ST_SEND:   if (r_pt == LAST_PT) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.valid)    w_state_nxt = ST_RECORD;
                else if (w_to_exp) w_state_nxt = ST_ERR;
            end
            ST_RECORD: w_state_nxt = w_last ? ST_DONE : ST_PRIME;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_viol) w_state_nxt = ST_ERR;
    end

    // mem_addr runs one ahead of the point being loaded: PRIME presents the
    // object base so the ROM word is ready in the first SEND cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_obj        <= '0;
            r_num        <= '0;
            r_inside_cnt <= '0;
            r_pt         <= '0;
            r_mem_addr   <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_pt_vld     <= 1'b0;
            r_inside     <= 1'b0;
        end else begin
            r_x      <= '0;
            r_y      <= '0;
            r_pt_vld <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (bus.start && (bus.num_obj != '0)) begin
                        r_num        <= bus.num_obj;
                        r_inside_cnt <= '0;
                        r_obj        <= '0;
                        r_mem_addr   <= '0;
                    end
                end
                ST_PRIME: begin
                    r_pt       <= '0;
                    r_mem_addr <= r_mem_addr + 1'b1;
                end
                ST_SEND: begin
                    if (!w_viol) begin
                        r_x      <= bus.mem_x;
                        r_y      <= bus.mem_y;
                        r_pt_vld <= 1'b1;
                    end
                    r_pt       <= r_pt + 1'b1;
                    r_mem_addr <= r_mem_addr + 1'b1;
                end
                ST_WAIT: if (bus.valid) r_inside <= bus.is_inside;
                ST_RECORD: begin
                    if (r_inside) r_inside_cnt <= r_inside_cnt + 1'b1;
                    if (!w_last) begin
                        r_obj      <= r_obj + 1'b1;
                        r_mem_addr <= obj_base(OBJ_W'(r_obj + 1'b1));
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.X          = r_x;
    assign bus.Y          = r_y;
    assign bus.pt_vld     = r_pt_vld;
    assign bus.res_we     = (r_state == ST_RECORD);
    assign bus.res_addr   = r_obj;
    assign bus.res_data   = r_inside;
    assign bus.inside_cnt = r_inside_cnt;
    assign bus.busy       = w_busy;
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err        = (r_state == ST_ERR);
endmodule

// File: tb/tb_geofence_host.sv
// Directed bench for geofence_host: ROM model, hand-driven judge responses.
module tb_geofence_host;
    import geofence_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    geofence_host_if bus();
    geofence_host dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [COORD_W-1:0] rom_x [0:511];
    logic [COORD_W-1:0] rom_y [0:511];

    always @(posedge clk) begin
        bus.mem_x <= rom_x[bus.mem_addr];
        bus.mem_y <= rom_y[bus.mem_addr];
    end

    int   n_wr, n_ptv;
    logic mon_clr;
    always @(posedge clk) begin
        if (mon_clr) begin
            n_wr  <= 0;
            n_ptv <= 0;
        end else begin
            if (bus.res_we) n_wr  <= n_wr + 1;
            if (bus.pt_vld) n_ptv <= n_ptv + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic do_start(input int n);
        bus.num_obj = 7'(n);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Point 0 shows up first_wait negedges from now: 2 after lowering start,
    // 3 after lowering valid (the RECORD cycle).
    task automatic send_pts(input int obj, input int base, input int first_wait);
        for (int i = 0; i < first_wait - 1; i++) begin
            @(negedge clk);
            chk($sformatf("o%0d_pre_vld", obj), 32'(bus.pt_vld), 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("o%0d_p%0d_vld", obj, k), 32'(bus.pt_vld), 32'd1);
            chk($sformatf("o%0d_p%0d_x", obj, k), 32'(bus.X), 32'(rom_x[base + k]));
            chk($sformatf("o%0d_p%0d_y", obj, k), 32'(bus.Y), 32'(rom_y[base + k]));
            @(negedge clk);
        end
        chk($sformatf("o%0d_post_vld", obj), 32'(bus.pt_vld), 32'd0);
        chk($sformatf("o%0d_post_x", obj), 32'(bus.X), 32'd0);
    endtask

    task automatic judge(input int obj, input int lat, input bit ins);
        repeat (lat - 1) @(negedge clk);
        bus.valid     = 1'b1;
        bus.is_inside = ins;
        @(negedge clk);
        bus.valid     = 1'b0;
        bus.is_inside = 1'b0;
        chk($sformatf("o%0d_we", obj), 32'(bus.res_we), 32'd1);
        chk($sformatf("o%0d_waddr", obj), 32'(bus.res_addr), 32'(obj));
        chk($sformatf("o%0d_wdata", obj), 32'(bus.res_data), 32'(ins));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"},      32'(bus.X), 32'd0);
        chk({tag, "_y"},      32'(bus.Y), 32'd0);
        chk({tag, "_vld"},    32'(bus.pt_vld), 32'd0);
        chk({tag, "_we"},     32'(bus.res_we), 32'd0);
        chk({tag, "_done"},   32'(bus.done), 32'd0);
        chk({tag, "_err"},    32'(bus.err), 32'd0);
        chk({tag, "_busy"},   32'(bus.busy), 32'd0);
        chk({tag, "_addr"},   32'(bus.mem_addr), 32'd0);
        chk({tag, "_icnt"},   32'(bus.inside_cnt), 32'd0);
        chk({tag, "_raddr"},  32'(bus.res_addr), 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 512; a++) begin
            rom_x[a] = 10'((a * 13 + 7) % 1024);
            rom_y[a] = 10'((a * 29 + 3) % 1024);
        end
        // object 0: test point (5,5) inside a hexagon spanning 0..10
        rom_x[0] = 10'd5;  rom_y[0] = 10'd5;
        rom_x[1] = 10'd0;  rom_y[1] = 10'd5;
        rom_x[2] = 10'd3;  rom_y[2] = 10'd0;
        rom_x[3] = 10'd7;  rom_y[3] = 10'd0;
        rom_x[4] = 10'd10; rom_y[4] = 10'd5;
        rom_x[5] = 10'd7;  rom_y[5] = 10'd10;
        rom_x[6] = 10'd3;  rom_y[6] = 10'd10;

        bus.start = 1'b0; bus.num_obj = '0; bus.valid = 1'b0; bus.is_inside = 1'b0;
        mon_clr = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset   = 1'b0;
        mon_clr = 1'b0;
        @(negedge clk);

        // single object, judge says inside after 20 cycles
        do_start(1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        send_pts(0, 0, 2);
        judge(0, 20, 1'b1);
        @(negedge clk);
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_busy_end", 32'(bus.busy), 32'd0);
        chk("t1_icnt", 32'(bus.inside_cnt), 32'd1);
        chk("t1_nwr", 32'(n_wr), 32'd1);
        chk("t1_nptv", 32'(n_ptv), 32'd7);

        // four objects, verdicts 1,0,1,1 with mixed latency
        clr_mon();
        do_start(4);
        chk("t2_done_clr", 32'(bus.done), 32'd0);
        chk("t2_icnt_clr", 32'(bus.inside_cnt), 32'd0);
        send_pts(0, 0, 2);   judge(0, 5, 1'b1);
        send_pts(1, 7, 3);   judge(1, 50, 1'b0);
        send_pts(2, 14, 3);  judge(2, 17, 1'b1);
        send_pts(3, 21, 3);  judge(3, 33, 1'b1);
        @(negedge clk);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_icnt", 32'(bus.inside_cnt), 32'd3);
        chk("t2_nwr", 32'(n_wr), 32'd4);
        chk("t2_nptv", 32'(n_ptv), 32'd28);

        // judge stays silent: err TIMEOUT+1 cycles after the 7th point
        clr_mon();
        do_start(1);
        send_pts(0, 0, 2);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("t3_err_early", 32'(bus.err), 32'd0);
        chk("t3_busy_early", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("t3_err", 32'(bus.err), 32'd1);
        chk("t3_busy", 32'(bus.busy), 32'd0);
        chk("t3_nwr", 32'(n_wr), 32'd0);
        chk("t3_nptv", 32'(n_ptv), 32'd7);

        // zero-object run out of ERR: straight to DONE, err cleared
        clr_mon();
        do_start(0);
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_err", 32'(bus.err), 32'd0);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_nptv", 32'(n_ptv), 32'd0);
        chk("t4_nwr", 32'(n_wr), 32'd0);

        // valid while the 3rd point is on the bus
        clr_mon();
        do_start(2);
        repeat (4) @(negedge clk);
        chk("t5_p2_x", 32'(bus.X), 32'(rom_x[2]));
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        chk("t5_err", 32'(bus.err), 32'd1);
        chk("t5_vld", 32'(bus.pt_vld), 32'd0);
        @(negedge clk);
        chk("t5_vld2", 32'(bus.pt_vld), 32'd0);
        chk("t5_nwr", 32'(n_wr), 32'd0);

        // reset in the middle of object 2's points, then a clean rerun
        clr_mon();
        do_start(3);
        send_pts(0, 0, 2);   judge(0, 8, 1'b0);
        send_pts(1, 7, 3);   judge(1, 12, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_mid_vld", 32'(bus.pt_vld), 32'd1);
        #1 reset = 1'b1;
        #1 chk_reset_vals("t6_rst");
        @(negedge clk);
        reset = 1'b0;
        chk("t6_nwr", 32'(n_wr), 32'd2);
        clr_mon();
        do_start(2);
        send_pts(0, 0, 2);   judge(0, 6, 1'b1);
        send_pts(1, 7, 3);   judge(1, 9, 1'b0);
        @(negedge clk);
        chk("t6_done", 32'(bus.done), 32'd1);
        chk("t6_icnt", 32'(bus.inside_cnt), 32'd1);
        chk("t6_nwr2", 32'(n_wr), 32'd2);
        chk("t6_nptv", 32'(n_ptv), 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
